// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the unidade_controle multi-cycle controller.
// Holds the opcode constants, the FSM state encoding, the instruction field
// positions, the bus widths and a sign-extension helper for the 6-bit immediate.
package unidade_controle_pkg;

  localparam int unsigned AddrW  = 8;
  localparam int unsigned DataW  = 8;
  localparam int unsigned InstrW = 16;
  localparam int unsigned RegAW  = 3;

  // Instruction field positions
  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 9;
  localparam int unsigned Rs1Msb = 8;
  localparam int unsigned Rs1Lsb = 6;
  localparam int unsigned Rs2Msb = 5;
  localparam int unsigned Rs2Lsb = 3;
  localparam int unsigned Imm6W  = 6;

  // Opcodes; 8..14 are NOP
  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpAddi = 4'd4;
  localparam logic [3:0] OpLi   = 4'd5;
  localparam logic [3:0] OpBeq  = 4'd6;
  localparam logic [3:0] OpJmp  = 4'd7;
  localparam logic [3:0] OpHalt = 4'd15;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  function automatic logic [DataW-1:0] sext6(input logic [Imm6W-1:0] v);
    return {{(DataW - Imm6W){v[Imm6W-1]}}, v};
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Bus bundle between the controller and its instruction memory / register file.
// master: controller side (drives fetch request/address, reg read/write addresses, write data).
// slave:  memory + register file side (drives ack, instruction word, read data).
interface unidade_controle_if
  import unidade_controle_pkg::*;
  ();

  logic              imem_req;
  logic [AddrW-1:0]  imem_addr;
  logic              imem_ack;
  logic [InstrW-1:0] imem_data;
  logic [RegAW-1:0]  ra1;
  logic [RegAW-1:0]  ra2;
  logic [DataW-1:0]  rd1;
  logic [DataW-1:0]  rd2;
  logic [RegAW-1:0]  wa3;
  logic              we3;
  logic [DataW-1:0]  wd3;

  modport master (
    output imem_req, imem_addr, ra1, ra2, wa3, we3, wd3,
    input  imem_ack, imem_data, rd1, rd2
  );

  modport slave (
    input  imem_req, imem_addr, ra1, ra2, wa3, we3, wd3,
    output imem_ack, imem_data, rd1, rd2
  );

endinterface

// File: rtl/unidade_controle_ula.sv
// ula: combinational 8-bit ALU for ADD/SUB/AND/OR and the ADDI add.
// Ports: op_i opcode, a_i/b_i register operands, imm6_i raw 6-bit immediate,
//        y_o result (modulo 256). Other opcodes yield zero.
module ula
  import unidade_controle_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  input  logic [Imm6W-1:0] imm6_i,
  output logic [DataW-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OpAdd:   y_o = a_i + b_i;
      OpSub:   y_o = a_i - b_i;
      OpAnd:   y_o = a_i & b_i;
      OpOr:    y_o = a_i | b_i;
      OpAddi:  y_o = a_i + sext6(imm6_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle controller (FETCH/DECODE/EXECUTE/WRITEBACK/HALT)
// for a 16-bit instruction, 8-bit datapath machine.
// Ports: clk, rst (async, active-high); bus (master modport) carrying the
//        instruction fetch handshake and register-file read/write ports;
//        pc current program counter; halted high once HALT executed.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter logic [AddrW-1:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  unidade_controle_if.master  bus,
  output logic [AddrW-1:0]    pc,
  output logic                halted
);

  state_e             state_q, state_d;
  logic [AddrW-1:0]   pc_q, pc_d;
  logic [InstrW-1:0]  ir_q, ir_d;
  logic [DataW-1:0]   result_q, result_d;
  logic               imem_req_q, imem_req_d;

  logic [3:0]         op;
  logic [RegAW-1:0]   rd_f, rs1_f, rs2_f;
  logic [Imm6W-1:0]   imm6;
  logic [DataW-1:0]   imm8;
  logic [DataW-1:0]   ula_y;
  logic               is_beq;
  logic               is_wb_op;

  assign op    = ir_q[OpMsb:OpLsb];
  assign rd_f  = ir_q[RdMsb:RdLsb];
  assign rs1_f = ir_q[Rs1Msb:Rs1Lsb];
  assign rs2_f = ir_q[Rs2Msb:Rs2Lsb];
  assign imm6  = ir_q[Imm6W-1:0];
  assign imm8  = ir_q[DataW-1:0];

  assign is_beq   = (op == OpBeq);
  assign is_wb_op = op inside {OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpLi};

  // BEQ compares rd-field register against rs1-field register
  assign bus.ra1 = is_beq ? rd_f  : rs1_f;
  assign bus.ra2 = is_beq ? rs1_f : rs2_f;

  ula u_ula (
    .op_i   (op),
    .a_i    (bus.rd1),
    .b_i    (bus.rd2),
    .imm6_i (imm6),
    .y_o    (ula_y)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    result_d = result_q;
    unique case (state_q)
      StFetch: begin
        // Ack only counts once the request is actually visible on the bus
        if (imem_req_q && bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        if (is_wb_op) begin
          result_d = (op == OpLi) ? imm8 : ula_y;
          state_d  = StWriteback;
        end else begin
          state_d = StFetch;
          case (op)
            OpBeq: begin
              pc_d = pc_q + 8'd1 + ((bus.rd1 == bus.rd2) ? sext6(imm6) : 8'd0);
            end
            OpJmp:   pc_d = imm8;
            OpHalt:  state_d = StHalt;
            default: pc_d = pc_q + 8'd1;
          endcase
        end
      end
      StWriteback: begin
        pc_d    = pc_q + 8'd1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
    // Registered so the request stays low during reset and rises one edge later
    imem_req_d = (state_d == StFetch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      result_q   <= '0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      result_q   <= result_d;
      imem_req_q <= imem_req_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.we3       = (state_q == StWriteback);
  assign bus.wa3       = rd_f;
  assign bus.wd3       = result_q;
  assign pc            = pc_q;
  assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc;
  logic       halted;

  unidade_controle_if bus ();

  unidade_controle #(.RESET_PC(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [7:0]  regs [8];
  logic        ack_tied = 1'b0;
  int          ack_delay = 0;
  int          req_cnt = 0;
  int          cyc = 0;
  logic [2:0]  wlog_a [$];
  logic [7:0]  wlog_d [$];
  int          wlog_c [$];
  int          errors = 0;
  int          checks = 0;

  assign bus.imem_data = mem[bus.imem_addr];
  assign bus.imem_ack  = ack_tied | (bus.imem_req && (req_cnt >= ack_delay));
  assign bus.rd1       = regs[bus.ra1];
  assign bus.rd2       = regs[bus.ra2];

  // Register-file model, memory wait-state counter and write log
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    req_cnt <= (bus.imem_req && !bus.imem_ack) ? req_cnt + 1 : 0;
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      wlog_a.delete();
      wlog_d.delete();
      wlog_c.delete();
    end else if (bus.we3) begin
      if (bus.wa3 != 3'd0) regs[bus.wa3] <= bus.wd3;
      wlog_a.push_back(bus.wa3);
      wlog_d.push_back(bus.wd3);
      wlog_c.push_back(cyc);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
  endtask

  task automatic reset_run();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_reached: halted=%b required 1 within %0d cycles", halted, budget);
    end
  endtask

  task automatic test_reset();
    clear_mem();
    ack_tied = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h required 00", pc); end
    checks++;
    if (bus.we3 !== 1'b0) begin errors++; $display("FAIL rst_we3: got %b required 0", bus.we3); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b required 0", halted); end
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req: got %b required 0", bus.imem_req);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rst_req_rise: got %b required 1", bus.imem_req);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pc !== 8'h01) begin errors++; $display("FAIL rst_first_nop_pc: got %h required 01", pc); end
    ack_tied = 1'b0;
  endtask

  task automatic test_alu_wrap();
    int bad;
    clear_mem();
    mem[0] = 16'h5205;  // LI r1,05
    mem[1] = 16'h54FE;  // LI r2,FE
    mem[2] = 16'h0650;  // ADD r3,r1,r2
    mem[3] = 16'hF000;  // HALT
    ack_delay = 0;
    reset_run();
    wait_halt(100);
    checks++;
    if (wlog_a.size() !== 3) begin
      errors++; $display("FAIL wrap_write_count: got %0d required 3", wlog_a.size());
    end else begin
      checks++;
      if (wlog_a[2] !== 3'd3 || wlog_d[2] !== 8'h03) begin
        errors++; $display("FAIL wrap_add: got wa3=%0d wd3=%h required 3/03", wlog_a[2], wlog_d[2]);
      end
      checks++;
      if (wlog_a[0] !== 3'd1 || wlog_d[0] !== 8'h05 || wlog_a[1] !== 3'd2 || wlog_d[1] !== 8'hFE)
      begin
        errors++;
        $display("FAIL wrap_li: got %0d/%h %0d/%h required 1/05 2/FE",
                 wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1]);
      end
      checks++;
      if (wlog_c[1] - wlog_c[0] !== 4 || wlog_c[2] - wlog_c[1] !== 4) begin
        errors++;
        $display("FAIL wrap_cycles: got %0d,%0d required 4,4",
                 wlog_c[1] - wlog_c[0], wlog_c[2] - wlog_c[1]);
      end
    end
    checks++;
    if (pc !== 8'h03) begin errors++; $display("FAIL halt_pc: got %h required 03", pc); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h03 || bus.we3 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_hold: got %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0] exp_a [7];
    logic [7:0] exp_d [7];
    clear_mem();
    mem[0] = 16'h525A;  // LI r1,5A
    mem[1] = 16'h540F;  // LI r2,0F
    mem[2] = 16'h1650;  // SUB r3,r1,r2
    mem[3] = 16'h2850;  // AND r4,r1,r2
    mem[4] = 16'h3A50;  // OR  r5,r1,r2
    mem[5] = 16'h4CB0;  // ADDI r6,r2,-16
    mem[6] = 16'h0050;  // ADD r0,r1,r2
    mem[7] = 16'hF000;
    exp_a = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    exp_d = '{8'h5A, 8'h0F, 8'h4B, 8'h0A, 8'h5F, 8'hFF, 8'h69};
    ack_delay = 1;
    reset_run();
    wait_halt(200);
    checks++;
    if (wlog_a.size() !== 7) begin
      errors++; $display("FAIL ops_write_count: got %0d required 7", wlog_a.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (wlog_a[i] !== exp_a[i] || wlog_d[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL ops_write%0d: got %0d/%h required %0d/%h",
                   i, wlog_a[i], wlog_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_ack_delay();
    int bad;
    clear_mem();
    mem[0] = 16'h525A;
    mem[1] = 16'hF000;
    ack_delay = 3;
    reset_run();
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || bus.imem_ack !== 1'b0 ||
          dut.ir_q !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ack_wait_stable: got %0d bad required 0", bad); end
    @(negedge clk);
    checks++;
    if (bus.imem_ack !== 1'b1 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL ack_arrive: got ack=%b req=%b required 1/1", bus.imem_ack, bus.imem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.ir_q !== 16'h525A || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL ack_latch: got ir=%h req=%b required 525A/0", dut.ir_q, bus.imem_req);
    end
    wait_halt(100);
    checks++;
    if (wlog_a.size() !== 1 || wlog_d[0] !== 8'h5A || wlog_a[0] !== 3'd1) begin
      errors++; $display("FAIL ack_writes: got %0d writes required 1 of 1/5A", wlog_a.size());
    end
  endtask

  task automatic test_beq();
    clear_mem();
    mem[0]     = 16'h5207;  // LI r1,07
    mem[1]     = 16'h5407;  // LI r2,07
    mem[2]     = 16'h7010;  // JMP 10
    mem[8'h10] = 16'h62BE;  // BEQ r1,r2,-2
    mem[8'h0F] = 16'hF000;
    mem[8'h11] = 16'hF000;
    ack_delay = 0;
    reset_run();
    wait_halt(100);
    checks++;
    if (pc !== 8'h0F) begin errors++; $display("FAIL beq_taken_pc: got %h required 0F", pc); end
    checks++;
    if (wlog_a.size() !== 2) begin
      errors++; $display("FAIL beq_writes: got %0d required 2", wlog_a.size());
    end
    mem[1] = 16'h5408;      // LI r2,08
    reset_run();
    wait_halt(100);
    checks++;
    if (pc !== 8'h11) begin errors++; $display("FAIL beq_not_taken_pc: got %h required 11", pc); end
  endtask

  task automatic test_jmp_wrap();
    int k;
    int n;
    clear_mem();
    mem[0] = 16'h70FF;      // JMP FF; FF holds NOP
    ack_delay = 0;
    reset_run();
    k = 0;
    while (pc !== 8'hFF && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (pc !== 8'hFF) begin errors++; $display("FAIL jmp_pc: got %h required FF", pc); end
    n = 0;
    while (pc === 8'hFF && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pc !== 8'h00 || n != 3) begin
      errors++; $display("FAIL nop_wrap: got pc=%h after %0d cycles required 00 after 3", pc, n);
    end
    checks++;
    if (wlog_a.size() !== 0 || halted !== 1'b0) begin
      errors++; $display("FAIL jmp_side_effects: got %0d writes halted=%b required 0/0",
                         wlog_a.size(), halted);
    end
  endtask

  task automatic test_rst_mid_wb();
    int k;
    clear_mem();
    mem[0]     = 16'h7020;  // JMP 20
    mem[8'h20] = 16'h5233;  // LI r1,33
    mem[8'h21] = 16'hF000;
    ack_delay = 0;
    reset_run();
    k = 0;
    while (bus.we3 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.we3 !== 1'b1 || pc !== 8'h20) begin
      errors++; $display("FAIL wb_reached: got we3=%b pc=%h required 1/20", bus.we3, pc);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.we3 !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_async_drop: got we3=%b req=%b required 0/0",
                         bus.we3, bus.imem_req);
    end
    checks++;
    if (pc !== 8'h00 || halted !== 1'b0) begin
      errors++; $display("FAIL rst_async_pc: got pc=%h halted=%b required 00/0", pc, halted);
    end
    checks++;
    if (wlog_a.size() !== 0) begin
      errors++; $display("FAIL rst_no_write: got %0d writes required 0", wlog_a.size());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_wrap();
    test_alu_ops();
    test_ack_delay();
    test_beq();
    test_jmp_wrap();
    test_rst_mid_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
